// File: rtl/fpcvt_pkg.sv
// Shared FPCVT constants: default code/linear widths, expander state encoding, largest decodable magnitude.
package fpcvt_pkg;

  localparam int unsigned EXP_W = 3;
  localparam int unsigned SIG_W = 4;
  localparam int unsigned OUT_W = 12;

  localparam int unsigned MAX_LINEAR = ((1 << SIG_W) - 1) << ((1 << EXP_W) - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/fp_linear_expander_if.sv
// Code-in / linear-out handshake bundle for fp_linear_expander.
interface fp_linear_expander_if #(
  parameter int unsigned EXP_W = fpcvt_pkg::EXP_W,
  parameter int unsigned SIG_W = fpcvt_pkg::SIG_W,
  parameter int unsigned OUT_W = fpcvt_pkg::OUT_W
);

  logic             in_valid;
  logic             in_ready;
  logic [EXP_W-1:0] exponent;
  logic [SIG_W-1:0] significand;
  logic             fifth_bit;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] linear;
  logic             busy;

  modport master (
    output in_valid, exponent, significand, fifth_bit, out_ready,
    input  in_ready, out_valid, linear, busy
  );

  modport slave (
    input  in_valid, exponent, significand, fifth_bit, out_ready,
    output in_ready, out_valid, linear, busy
  );

endinterface

// File: rtl/fp_linear_expander.sv
// Float code (E,S[,F]) to linear magnitude via one-bit-per-cycle shifter.
// Optional FPCVT_MIDPOINT_EN keeps F as a guard bit to reconstruct the interval midpoint.
module fp_linear_expander #(
  parameter int unsigned EXP_W = fpcvt_pkg::EXP_W,
  parameter int unsigned SIG_W = fpcvt_pkg::SIG_W,
  parameter int unsigned OUT_W = fpcvt_pkg::OUT_W
) (
  input logic clk,
  input logic rst,
  fp_linear_expander_if.slave bus
);
  import fpcvt_pkg::*;

  localparam int unsigned ACC_W = OUT_W + 1;

  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic [EXP_W-1:0] cnt;
  logic [OUT_W-1:0] linear_q;
  logic             out_valid_q;
  logic             guard;
  logic             unused_fifth;

  // Guard bit sits below the significand so the final [OUT_W:1] slice yields F<<(E-1).
`ifdef FPCVT_MIDPOINT_EN
  assign guard        = bus.fifth_bit;
  assign unused_fifth = 1'b0;
`else
  assign guard        = 1'b0;
  assign unused_fifth = bus.fifth_bit;
`endif

  assign bus.in_ready  = (state == ST_IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.linear    = linear_q;
  assign bus.busy      = (state == ST_SHIFT) || (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      out_valid_q <= 1'b0;
      linear_q    <= '0;
      acc         <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            acc   <= ACC_W'({bus.significand, guard});
            cnt   <= bus.exponent;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt != '0) begin
            acc <= acc << 1;
            cnt <= cnt - EXP_W'(1);
          end else begin
            linear_q    <= acc[OUT_W:1];
            out_valid_q <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fp_linear_expander.md
Name: fp_linear_expander

Overview:
Sequential decoder that converts the 3-bit exponent / 4-bit significand floating-point code back into a 12-bit unsigned linear magnitude. It is the inverse of the lab's linear-to-float compressor.
- Value reconstructed as significand << exponent, using an iterative one-bit-per-cycle shifter.
- valid/ready handshake on both input and output.
- Used for round-trip checking and display back-end in the FPCVT datapath.

Parameters:
EXP_W, 3, exponent width
SIG_W, 4, significand width
OUT_W, 12, linear output width; must satisfy OUT_W >= SIG_W + 2**EXP_W - 1

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  exponent/significand/fifth_bit are valid
in_ready  output  1  block can accept a code
exponent  input  EXP_W  shift amount E
significand  input  SIG_W  mantissa S
fifth_bit  input  1  rounding/guard bit F (used only with the optional feature)
out_valid  output  1  linear holds a finished result
out_ready  input  1  consumer takes result
linear  output  OUT_W  reconstructed magnitude
busy  output  1  high in SHIFT or DONE

Behaviour:
- Clocking and reset: one clock, clk; rst is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, linear=0, accumulator=0, count=0.
- in_ready = (state==IDLE) && !rst; it is combinational.
- States:
  - IDLE: in_ready=1. When in_valid&&in_ready, load acc = zero-extended {S,F} (OUT_W+1 bits, guard bit at LSB) and cnt=E, then go to SHIFT. Inputs are sampled only on the accept edge; later input changes are ignored.
  - SHIFT: if cnt!=0, acc <= acc<<1 and cnt <= cnt-1. If cnt==0, linear <= acc[OUT_W:1], out_valid <= 1, go to DONE.
  - DONE: out_valid=1 and linear held stable. When out_valid&&out_ready, out_valid <= 0 and go to IDLE. No new code is accepted in the same cycle.
- Latency: out_valid rises E+1 cycles after the accept edge (E=0 gives 1 cycle, E=7 gives 8 cycles). Minimum issue interval is E+3 cycles.
- Width: max result is 15<<7 = 1920 (plus 64 with the optional feature), so no overflow at default widths. No saturation logic.
- Unnormalized codes (S MSB clear, any E) decode by the same rule; there is no special case.
- Reset mid-operation: an in-flight result is discarded; out_valid=0 on the next edge.
- rst has priority over every handshake event.
- linear holds its last value after handshake until the next completion (it is not cleared).

Optional Feature:
Macro FPCVT_MIDPOINT_EN.
- Defined: F is kept as the guard bit, so linear = (S<<E) + (F<<(E-1)) for E>0. This reconstructs the interval midpoint implied by the rounding bit. For E=0, F is dropped.
- Undefined: the guard bit is loaded as 0 regardless of fifth_bit, so linear = S<<E. The fifth_bit port still exists but is unused.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package fpcvt_pkg holds:
  - EXP_W/SIG_W/OUT_W default constants, shared with the compressor.
  - State encoding localparams ST_IDLE, ST_SHIFT, ST_DONE.
  - The MAX_LINEAR constant (1920).
- No sub-module: the shifter, counter and FSM are small enough to stay flat in one module.

Test Plan:
- Reset: hold rst 3 cycles with in_valid=1 -> out_valid=0, linear=0, in_ready=0 during rst; in_ready=1 the cycle after release; no accept during rst.
- E=0, S=5 accepted -> out_valid 1 cycle later, linear=5; out_ready=1 returns to IDLE next edge.
- E=7, S=15 accepted -> out_valid exactly 8 cycles after accept, linear=1920; busy high throughout.
- E=4, S=9, F=1 -> linear=144 without FPCVT_MIDPOINT_EN; linear=152 with it; E=0, S=3, F=1 -> 3 in both builds.
- Backpressure: result ready with out_ready=0 for 5 cycles -> linear stable, in_ready=0, new in_valid pulses not accepted; after out_ready=1, the next code is accepted and decoded correctly.
- rst asserted on the 3rd SHIFT cycle of E=6, S=12 -> state IDLE, out_valid never rises for that code; a subsequent E=1, S=8 returns 16.
